alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the team's 8-bit combinational ALU.
- Same 3-bit opcode space, generalised to WIDTH bits.
- Adds registered results with a valid/ready handshake and backpressure.
- Adds zero/carry/greater-than flags that travel with each result, plus a saturating completed-operation counter.
- Sits between the operand sequencer (upstream) and the result consumer (downstream).

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 2).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept an operand beat this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- OPcode  input  3  operation select.
- carry_in  input  1  carry input, used by ADC only.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result this cycle.
- out  output  WIDTH  result.
- carry_out  output  1  carry/shift-out bit of the result's operation.
- z_flag  output  1  out == 0.
- c_flag  output  1  A > B, unsigned, for every opcode.
- op_count  output  CNT_W  number of results accepted downstream.

Behaviour:
- Reset (rst high at a clock edge): s1_valid=0, s2_valid=0, out_valid=0, out=0, carry_out=0, z_flag=0, c_flag=0, op_count=0. Reset overrides any in-flight beat; pipeline contents are discarded.
- Handshake: a beat transfers when valid && ready at the rising edge.
  - Once out_valid=1, out, carry_out, z_flag and c_flag are held stable until out_ready=1.
  - in_valid must not depend on in_ready.
- Stage 1 registers A, B, OPcode and carry_in.
  - s1 loads when in_valid && in_ready.
  - in_ready = !s1_valid || s2_load.
  - in_ready is combinational from out_ready, through s2_load.
- Stage 2 computes the operation from the stage-1 registers and registers the result and flags.
  - s2_load = s1_valid && (!s2_valid || out_ready).
  - out_valid = s2_valid.
- Latency: 2 cycles from input accept to out_valid with no backpressure. Throughput is one beat per cycle.
- Simultaneous events:
  - Accept-in and accept-out in the same cycle are both honoured; a full pipeline with out_ready=1 keeps streaming.
  - s1 emptying while a new beat loads leaves s1_valid=1.
- Opcodes; all arithmetic is unsigned and WIDTH+1 bits wide internally.
  - 000 ADD: {carry_out,out} = A+B; carry_in is ignored.
  - 001 ADC: {carry_out,out} = A+B+carry_in.
  - 010 AND: out = A&B, carry_out=0.
  - 011 OR: out = A|B, carry_out=0.
  - 100 XOR: out = A^B, carry_out=0.
  - 101 GT: out = {WIDTH-1 zeros, A>B}, carry_out=0.
  - 110 SHLA: out = A<<1, carry_out = A[WIDTH-1].
  - 111 SHLB: out = B<<1, carry_out = B[WIDTH-1].
- No opcode produces X; every output is always a known value.
- Flags:
  - z_flag = (out==0), computed on the final stage-2 value.
  - c_flag = A>B for every opcode.
- op_count:
  - Increments by 1 on each out_valid && out_ready.
  - Saturates at all-ones and does not wrap.
  - Cleared only by rst.

Optional Feature:
- Macro: ALU_PIPE_SAT_EN.
- When defined, ADD and ADC saturate: if the WIDTH+1-bit sum overflows, out = all-ones and carry_out=1. z_flag is then 0.
- When undefined, ADD and ADC wrap modulo 2^WIDTH, with carry_out = the sum's MSB.
- All other opcodes, the handshake and the latency are identical in both builds.

Test Plan (WIDTH=8):
1. Reset then single beat: rst high 2 cycles, then ADD A=0x12 B=0x34, out_ready=1 -> out_valid rises exactly 2 cycles after accept; out=0x46, carry_out=0, z_flag=0, c_flag=0, op_count=1.
2. Wrap vs saturation: ADC A=0xFF B=0x00 carry_in=1.
   - Without macro -> out=0x00, carry_out=1, z_flag=1.
   - With ALU_PIPE_SAT_EN -> out=0xFF, carry_out=1, z_flag=0.
3. Opcode sweep: A=0xC3, B=0x5A, opcodes 010..111 back-to-back -> results 0x42, 0xDB, 0x99, 0x01, 0x86 (carry_out=1), 0xB4 (carry_out=0). c_flag=1 on all; one result per cycle.
4. Backpressure: stream 4 beats with out_ready=0 -> in_ready drops after 2 accepts. out holds the first result stable. Releasing out_ready delivers all 4 beats in order with no loss or duplication; op_count=4.
5. Reset mid-operation: rst asserted with both stages full -> next cycle out_valid=0, in_ready=1, op_count=0. No stale result appears afterwards.
6. Counter saturation (CNT_W=2): 5 accepted results -> op_count reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/alu_pipe_if.sv
// Handshake and data bundle between the operand sequencer, alu_pipe and the result consumer.
// master = the side that supplies operands and consumes results; slave = alu_pipe.
interface alu_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       OPcode;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carry_out;
  logic             z_flag;
  logic             c_flag;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, A, B, OPcode, carry_in, out_ready,
    input  in_ready, out_valid, out, carry_out, z_flag, c_flag, op_count
  );

  modport slave (
    input  in_valid, A, B, OPcode, carry_in, out_ready,
    output in_ready, out_valid, out, carry_out, z_flag, c_flag, op_count
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready backpressure, result flags and a saturating op counter.
// Optional build macro ALU_PIPE_SAT_EN makes ADD/ADC saturate to all-ones instead of wrapping.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  // Returns {carry_out, out} for one operation.
  function automatic logic [WIDTH:0] alu_op(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [2:0]       op,
    input logic             cin
  );
    logic [WIDTH:0] sum;
    logic [WIDTH:0] r;
    r   = {(WIDTH+1){1'b0}};
    sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == 3'b001) ? cin : 1'b0};
    case (op)
      3'b000, 3'b001: begin
`ifdef ALU_PIPE_SAT_EN
        r = sum[WIDTH] ? {(WIDTH+1){1'b1}} : sum;
`else
        r = sum;
`endif
      end
      3'b010:  r = {1'b0, a & b};
      3'b011:  r = {1'b0, a | b};
      3'b100:  r = {1'b0, a ^ b};
      3'b101:  r = {1'b0, {(WIDTH-1){1'b0}}, (a > b)};
      3'b110:  r = {a, 1'b0};
      3'b111:  r = {b, 1'b0};
      default: r = {(WIDTH+1){1'b0}};
    endcase
    return r;
  endfunction

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [2:0]       s1_op_r;
  logic             s1_cin_r;
  logic             s2_valid_r;
  logic [WIDTH-1:0] out_r;
  logic             carry_r;
  logic             z_r;
  logic             c_r;
  logic [CNT_W-1:0] cnt_r;

  logic             s2_load_s;
  logic             s1_load_s;
  logic             in_ready_s;
  logic             out_fire_s;
  logic [WIDTH:0]   res_s;
  logic             z_s;
  logic             gt_s;

  // Handshake steering: stage 1 may refill in the same cycle it drains into stage 2.
  always_comb begin
    s2_load_s  = 1'b0;
    in_ready_s = 1'b0;
    s1_load_s  = 1'b0;
    out_fire_s = 1'b0;
    s2_load_s  = s1_valid_r && (!s2_valid_r || bus.out_ready);
    in_ready_s = !s1_valid_r || s2_load_s;
    s1_load_s  = bus.in_valid && in_ready_s;
    out_fire_s = s2_valid_r && bus.out_ready;
  end

  // Stage-2 datapath computed from the stage-1 registers.
  always_comb begin
    res_s = {(WIDTH+1){1'b0}};
    z_s   = 1'b0;
    gt_s  = 1'b0;
    res_s = alu_op(s1_a_r, s1_b_r, s1_op_r, s1_cin_r);
    z_s   = (res_s[WIDTH-1:0] == {WIDTH{1'b0}});
    gt_s  = (s1_a_r > s1_b_r);
  end

  // Stage 1: operand capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s1_op_r    <= 3'b000;
      s1_cin_r   <= 1'b0;
    end else if (s1_load_s) begin
      s1_valid_r <= 1'b1;
      s1_a_r     <= bus.A;
      s1_b_r     <= bus.B;
      s1_op_r    <= bus.OPcode;
      s1_cin_r   <= bus.carry_in;
    end else if (s2_load_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage 2: result and flags, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      out_r      <= {WIDTH{1'b0}};
      carry_r    <= 1'b0;
      z_r        <= 1'b0;
      c_r        <= 1'b0;
    end else if (s2_load_s) begin
      s2_valid_r <= 1'b1;
      out_r      <= res_s[WIDTH-1:0];
      carry_r    <= res_s[WIDTH];
      z_r        <= z_s;
      c_r        <= gt_s;
    end else if (out_fire_s) begin
      s2_valid_r <= 1'b0;
    end
  end

  // Completed-operation counter, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (out_fire_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = s2_valid_r;
  assign bus.out       = out_r;
  assign bus.carry_out = carry_r;
  assign bus.z_flag    = z_r;
  assign bus.c_flag    = c_r;
  assign bus.op_count  = cnt_r;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed table, multi-cycle corner sequences and random
// traffic against an arithmetic reference model; a second instance uses a 2-bit counter.
module tb_alu_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(8), .CNT_W(16)) bus ();
  alu_pipe_if #(.WIDTH(8), .CNT_W(2))  bus_c ();

  alu_pipe #(.WIDTH(8), .CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(bus));
  alu_pipe #(.WIDTH(8), .CNT_W(2))  dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  assign bus_c.in_valid  = bus.in_valid;
  assign bus_c.A         = bus.A;
  assign bus_c.B         = bus.B;
  assign bus_c.OPcode    = bus.OPcode;
  assign bus_c.carry_in  = bus.carry_in;
  assign bus_c.out_ready = bus.out_ready;

  typedef struct packed {
    logic [7:0] out;
    logic       co;
    logic       z;
    logic       c;
  } res_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    res_t       exp;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cnt16 = 0;
  int   cnt2  = 0;
  res_t exp_q[$];
  int   sat_log[$];
  logic hold_pend = 1'b0;
  res_t held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model written straight from the opcode table with integer arithmetic.
  function automatic res_t model(input logic [2:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic ci);
    res_t r;
    int   s;
    r = '0;
    s = 0;
    r.c = (a > b);
    case (op)
      3'd0, 3'd1: begin
        s = int'(a) + int'(b) + ((op == 3'd1) ? int'(ci) : 0);
`ifdef ALU_PIPE_SAT_EN
        r.out = (s > 255) ? 8'hFF : 8'(s);
`else
        r.out = 8'(s);
`endif
        r.co = (s > 255);
      end
      3'd2: r.out = a & b;
      3'd3: r.out = a | b;
      3'd4: r.out = a ^ b;
      3'd5: r.out = (a > b) ? 8'd1 : 8'd0;
      3'd6: begin s = int'(a) * 2; r.out = 8'(s); r.co = (s > 255); end
      3'd7: begin s = int'(b) * 2; r.out = 8'(s); r.co = (s > 255); end
      default: r.out = 8'd0;
    endcase
    r.z = (r.out == 8'd0);
    return r;
  endfunction

  // One clock cycle: drive, observe handshakes, score, advance to just after the next edge.
  task automatic step(input logic v, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic ci, input logic ordy,
                      input res_t e, output logic acc);
    res_t act;
    res_t want;
    logic ofire;
    bus.in_valid  = v;
    bus.OPcode    = op;
    bus.A         = a;
    bus.B         = b;
    bus.carry_in  = ci;
    bus.out_ready = ordy;
    #1;
    act = {bus.out, bus.carry_out, bus.z_flag, bus.c_flag};
    acc = v && bus.in_ready;
    if (hold_pend) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_data", 32'(act), 32'(held));
    end
    ofire = bus.out_valid && ordy;
    if (ofire) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(ofire), 32'd0);
      end else begin
        want = exp_q.pop_front();
        check("result", 32'(act), 32'(want));
        if (cnt16 < 65535) cnt16++;
        if (cnt2 < 3) cnt2++;
      end
    end
    hold_pend = bus.out_valid && !ordy;
    held = act;
    if (acc) exp_q.push_back(e);
    @(posedge clk);
    #1;
    check("op_count", 32'(bus.op_count), 32'(cnt16));
    check("op_count_sat", 32'(bus_c.op_count), 32'(cnt2));
    if (ofire) sat_log.push_back(int'(bus_c.op_count));
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step(1'b0, 3'd0, 8'd0, 8'd0, 1'b0, ordy, '0, acc);
  endtask

  task automatic send(input vec_t t, output int tries);
    logic acc;
    acc = 1'b0;
    tries = 0;
    while (!acc) begin
      step(1'b1, t.op, t.a, t.b, t.ci, 1'b1, t.exp, acc);
      tries++;
      if (!acc && tries > 50) begin
        check("send_timeout", 32'(tries), 32'd0);
        break;
      end
    end
  endtask

  task automatic drain(output int n);
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      idle(1'b1);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    cnt16 = 0;
    cnt2 = 0;
    hold_pend = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    vec_t bp[4];
    vec_t v;
    logic acc;
    int   tries;
    int   total;
    int   n;
    int   k;
    logic have;
    int   sat_exp[5];

    tbl[0] = '{3'd0, 8'h12, 8'h34, 1'b0, '{8'h46, 1'b0, 1'b0, 1'b0}};
`ifdef ALU_PIPE_SAT_EN
    tbl[1] = '{3'd1, 8'hFF, 8'h00, 1'b1, '{8'hFF, 1'b1, 1'b0, 1'b1}};
`else
    tbl[1] = '{3'd1, 8'hFF, 8'h00, 1'b1, '{8'h00, 1'b1, 1'b1, 1'b1}};
`endif
    tbl[2] = '{3'd2, 8'hC3, 8'h5A, 1'b0, '{8'h42, 1'b0, 1'b0, 1'b1}};
    tbl[3] = '{3'd3, 8'hC3, 8'h5A, 1'b0, '{8'hDB, 1'b0, 1'b0, 1'b1}};
    tbl[4] = '{3'd4, 8'hC3, 8'h5A, 1'b0, '{8'h99, 1'b0, 1'b0, 1'b1}};
    tbl[5] = '{3'd5, 8'hC3, 8'h5A, 1'b0, '{8'h01, 1'b0, 1'b0, 1'b1}};
    tbl[6] = '{3'd6, 8'hC3, 8'h5A, 1'b1, '{8'h86, 1'b1, 1'b0, 1'b1}};
    tbl[7] = '{3'd7, 8'hC3, 8'h5A, 1'b1, '{8'hB4, 1'b0, 1'b0, 1'b1}};
    sat_exp = '{1, 2, 3, 3, 3};

    bus.A = 8'd0; bus.B = 8'd0; bus.OPcode = 3'd0; bus.carry_in = 1'b0;
    @(posedge clk);
    #1;

    // Reset state and single-beat latency.
    do_reset(2);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_outputs", 32'({bus.out, bus.carry_out, bus.z_flag, bus.c_flag}), 32'd0);
    check("rst_op_count", 32'(bus.op_count), 32'd0);
    step(1'b1, 3'd0, 8'h12, 8'h34, 1'b0, 1'b1, tbl[0].exp, acc);
    check("single_accept", 32'(acc), 32'd1);
    check("lat_cycle1", 32'(bus.out_valid), 32'd0);
    idle(1'b0);
    check("lat_cycle2", 32'(bus.out_valid), 32'd1);
    check("single_out", 32'({bus.out, bus.carry_out, bus.z_flag, bus.c_flag}),
          32'({8'h46, 1'b0, 1'b0, 1'b0}));
    idle(1'b1);
    check("single_count", 32'(bus.op_count), 32'd1);

    // Directed table streamed back-to-back: one result per cycle.
    do_reset(1);
    total = 0;
    for (int i = 0; i < 8; i++) begin
      send(tbl[i], tries);
      total += tries;
    end
    check("table_no_stall", 32'(total), 32'd8);
    drain(n);
    check("table_drain_cycles", 32'(n), 32'd2);

    // Backpressure: only two beats fit, output holds, then everything drains in order.
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      bp[i].op = 3'(i + 1);
      bp[i].a  = 8'(8'h30 + 8'(i * 17));
      bp[i].b  = 8'(8'h21 * (i + 1));
      bp[i].ci = 1'b1;
      bp[i].exp = model(bp[i].op, bp[i].a, bp[i].b, bp[i].ci);
    end
    k = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      step(1'b1, bp[k].op, bp[k].a, bp[k].b, bp[k].ci, 1'b0, bp[k].exp, acc);
      if (cyc >= 2) check("bp_in_ready_low", 32'(acc), 32'd0);
      if (acc) k++;
    end
    check("bp_accepts", 32'(k), 32'd2);
    check("bp_first_held", 32'({bus.out, bus.carry_out, bus.z_flag, bus.c_flag}),
          32'(bp[0].exp));
    tries = 0;
    while (k < 4 && tries < 20) begin
      step(1'b1, bp[k].op, bp[k].a, bp[k].b, bp[k].ci, 1'b1, bp[k].exp, acc);
      if (acc) k++;
      tries++;
    end
    check("bp_all_sent", 32'(k), 32'd4);
    drain(n);
    check("bp_op_count", 32'(bus.op_count), 32'd4);

    // Reset with both stages full and a beat being offered.
    do_reset(1);
    step(1'b1, 3'd4, 8'hAA, 8'h0F, 1'b0, 1'b0, model(3'd4, 8'hAA, 8'h0F, 1'b0), acc);
    step(1'b1, 3'd3, 8'h01, 8'h02, 1'b0, 1'b0, model(3'd3, 8'h01, 8'h02, 1'b0), acc);
    check("mid_full", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    cnt16 = 0;
    cnt2 = 0;
    hold_pend = 1'b0;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_op_count", 32'(bus.op_count), 32'd0);
    repeat (4) idle(1'b1);

    // Saturating 2-bit counter on the second instance.
    do_reset(1);
    sat_log.delete();
    for (int i = 0; i < 5; i++) begin
      v = '{3'd2, 8'(i + 1), 8'hFF, 1'b0, model(3'd2, 8'(i + 1), 8'hFF, 1'b0)};
      send(v, tries);
    end
    drain(n);
    check("sat_log_len", 32'(sat_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < sat_log.size()) check("sat_seq", 32'(sat_log[i]), 32'(sat_exp[i]));
    end

    // Random traffic against the reference model.
    do_reset(1);
    have = 1'b0;
    v = '{3'd0, 8'd0, 8'd0, 1'b0, '0};
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        v.op = 3'($urandom_range(0, 7));
        v.a  = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom);
        v.b  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
        v.ci = 1'($urandom);
        v.exp = model(v.op, v.a, v.b, v.ci);
        have = 1'b1;
      end
      step(have, v.op, v.a, v.b, v.ci, 1'($urandom_range(0, 3) != 0), v.exp, acc);
      if (acc) have = 1'b0;
    end
    drain(n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
